// File: rtl/control_fsm.sv
// control_fsm: accumulator-machine sequencer (fetch, decode, memory/ALU execute, multi-cycle multiply).
module control_fsm #(
   parameter int DATA_W     = 32,
   parameter int OPC_W      = 4,
   parameter int MUL_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [DATA_W-1:0] acc,
   input  logic              mem_ready,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              ir_load,
   output logic              pc_inc,
   output logic              pc_load,
   output logic              acc_load,
   output logic [2:0]        alu_op,
   output logic              busy,
   output logic              halted,
   output logic              illegal
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MUL_WAIT, HALT} state_t;
   localparam int CW = $clog2(MUL_CYCLES + 1);
   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LOAD = 4'd1;
   localparam logic [3:0] OP_SET  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_MULT = 4'd4;
   localparam logic [3:0] OP_JNZ  = 4'd5;
   localparam logic [3:0] OP_JZ   = 4'd6;
   localparam logic [3:0] OP_JMP  = 4'd7;
   localparam logic [3:0] OP_SUB  = 4'd8;
   state_t          state, next;
   logic [3:0]      op, dec_op;
   logic [CW-1:0]   cnt;
   logic            bad, acc_zero, is_jump;
   function automatic logic [2:0] alu_map(input logic [3:0] o);
      return (o == OP_LOAD) ? 3'd1 : (o == OP_ADD) ? 3'd2 : (o == OP_MULT) ? 3'd3 :
             (o == OP_SUB) ? 3'd4 : 3'd0;
   endfunction
   // Anything above 8, including any set upper opcode bit, decodes as NOP-like illegal.
   assign bad      = opcode > OPC_W'(8);
   assign dec_op   = bad ? OP_NOP : opcode[3:0];
   assign acc_zero = acc == '0;
   assign is_jump  = dec_op == OP_JNZ || dec_op == OP_JZ || dec_op == OP_JMP;
   always_comb begin
      next = state;
      case (state)
         IDLE:     next = start ? FETCH : IDLE;
         FETCH:    next = mem_ready ? DECODE : FETCH;
         DECODE:   next = (dec_op == OP_NOP) ? HALT : is_jump ? FETCH : EXEC;
         EXEC:     next = !mem_ready ? EXEC : (op == OP_MULT) ? MUL_WAIT : FETCH;
         MUL_WAIT: next = (cnt == '0) ? FETCH : MUL_WAIT;
         HALT:     next = start ? FETCH : HALT;
         default:  next = IDLE;
      endcase
   end
   assign mem_rd   = state == FETCH || (state == EXEC && op != OP_SET);
   assign mem_wr   = state == EXEC && op == OP_SET;
   assign ir_load  = state == FETCH && mem_ready;
   assign pc_inc   = state == FETCH && mem_ready;
   assign pc_load  = state == DECODE && (dec_op == OP_JMP || (dec_op == OP_JNZ && !acc_zero) ||
                                         (dec_op == OP_JZ && acc_zero));
   assign acc_load = (state == EXEC && mem_ready && (op == OP_LOAD || op == OP_ADD || op == OP_SUB)) ||
                     (state == MUL_WAIT && cnt == '0);
   assign alu_op   = (state == DECODE) ? alu_map(dec_op) :
                     (state == EXEC || state == MUL_WAIT) ? alu_map(op) : 3'd0;
   assign busy     = state != IDLE && state != HALT;
   assign halted   = state == HALT;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         op      <= OP_NOP;
         cnt     <= '0;
         illegal <= 1'b0;
      end else begin
         state <= next;
         if (state == DECODE) begin
            op      <= dec_op;
            illegal <= illegal | bad;
         end
         if (state == EXEC && mem_ready && op == OP_MULT)
            cnt <= CW'(MUL_CYCLES - 1);
         else if (state == MUL_WAIT && cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed scenario checks of control_fsm, default build plus a wide-opcode, single-cycle-multiply build.
module tb_control_fsm;
   logic        clk, rst, start, mem_ready;
   logic [3:0]  opcode;
   logic [31:0] acc;
   logic        mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, busy, halted, illegal;
   logic [2:0]  alu_op;
   logic        b_start, b_ready;
   logic [5:0]  b_opcode;
   logic [15:0] b_acc;
   logic        b_rd, b_wr, b_ir, b_inc, b_pcl, b_ld, b_busy, b_halted, b_illegal;
   logic [2:0]  b_alu;
   int checks = 0;
   int errors = 0;

   control_fsm dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .acc(acc), .mem_ready(mem_ready),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
      .acc_load(acc_load), .alu_op(alu_op), .busy(busy), .halted(halted), .illegal(illegal)
   );

   control_fsm #(.DATA_W(16), .OPC_W(6), .MUL_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .opcode(b_opcode), .acc(b_acc), .mem_ready(b_ready),
      .mem_rd(b_rd), .mem_wr(b_wr), .ir_load(b_ir), .pc_inc(b_inc), .pc_load(b_pcl),
      .acc_load(b_ld), .alu_op(b_alu), .busy(b_busy), .halted(b_halted), .illegal(b_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %0d exp 0", mem_rd); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0d exp 0", halted); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0d exp 0", illegal); end
      checks++; if (alu_op !== 3'd0) begin errors++; $display("FAIL reset_alu_op got %0d exp 0", alu_op); end
      step;
      rst = 1'b0;
      step;
      step;
      checks++; if ({busy, mem_rd, mem_wr} !== 3'b000) begin errors++; $display("FAIL idle_no_start got %b exp 000", {busy, mem_rd, mem_wr}); end
   endtask

   task automatic test_reset_mid_fetch;
      start = 1'b1;
      step;
      start = 1'b0;
      mem_ready = 1'b0;
      #1;
      checks++; if ({mem_rd, busy} !== 2'b11) begin errors++; $display("FAIL fetch_entry got %b exp 11", {mem_rd, busy}); end
      rst = 1'b1;
      #1;
      checks++; if ({mem_rd, busy, illegal} !== 3'b000) begin errors++; $display("FAIL reset_mid_fetch got %b exp 000", {mem_rd, busy, illegal}); end
      step;
      rst = 1'b0;
      step;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL after_reset_idle got %0d exp 0", busy); end
   endtask

   task automatic test_add_stall;
      int rd_cnt, ld_cnt, wr_seen, alu_bad;
      rd_cnt = 0; ld_cnt = 0; wr_seen = 0; alu_bad = 0;
      start = 1'b1;
      step;
      start = 1'b0;
      opcode = 4'd3;
      mem_ready = 1'b1;
      #1;
      checks++; if ({ir_load, pc_inc, pc_load} !== 3'b110) begin errors++; $display("FAIL fetch_handshake got %b exp 110", {ir_load, pc_inc, pc_load}); end
      step;
      mem_ready = 1'b0;
      #1;
      checks++; if ({alu_op, mem_rd, mem_wr} !== {3'd2, 2'b00}) begin errors++; $display("FAIL add_decode got %b exp 01000", {alu_op, mem_rd, mem_wr}); end
      for (int i = 0; i < 3; i++) begin
         step;
         mem_ready = (i == 2);
         #1;
         rd_cnt += int'(mem_rd);
         ld_cnt += int'(acc_load);
         wr_seen += int'(mem_wr);
         if (alu_op !== 3'd2) alu_bad++;
         if (i == 2 && acc_load !== 1'b1) alu_bad++;
      end
      step;
      mem_ready = 1'b0;
      #1;
      checks++; if (rd_cnt !== 3) begin errors++; $display("FAIL add_rd_cycles got %0d exp 3", rd_cnt); end
      checks++; if (ld_cnt !== 1) begin errors++; $display("FAIL add_acc_load got %0d exp 1", ld_cnt); end
      checks++; if (wr_seen !== 0) begin errors++; $display("FAIL add_mem_wr got %0d exp 0", wr_seen); end
      checks++; if (alu_bad !== 0) begin errors++; $display("FAIL add_alu_timing got %0d exp 0", alu_bad); end
      checks++; if ({mem_rd, acc_load, alu_op} !== 5'b10000) begin errors++; $display("FAIL add_back_to_fetch got %b exp 10000", {mem_rd, acc_load, alu_op}); end
   endtask

   task automatic test_jumps;
      logic [3:0]  ops  [5] = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd7};
      logic [31:0] accs [5] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'd9};
      logic        exp_pl [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         opcode = ops[i];
         acc = accs[i];
         mem_ready = 1'b1;
         step;
         mem_ready = 1'b0;
         #1;
         checks++; if ({pc_load, pc_inc} !== {exp_pl[i], 1'b0}) begin errors++; $display("FAIL jump%0d_pc_load got %b exp %b0", i, {pc_load, pc_inc}, exp_pl[i]); end
         checks++; if ({mem_rd, mem_wr, busy} !== 3'b001) begin errors++; $display("FAIL jump%0d_decode got %b exp 001", i, {mem_rd, mem_wr, busy}); end
         step;
         checks++; if ({mem_rd, pc_load, acc_load} !== 3'b100) begin errors++; $display("FAIL jump%0d_refetch got %b exp 100", i, {mem_rd, pc_load, acc_load}); end
      end
      acc = '0;
   endtask

   task automatic test_load_set_sub;
      logic [3:0] ops   [3] = '{4'd1, 4'd2, 4'd8};
      logic [2:0] e_alu [3] = '{3'd1, 3'd0, 3'd4};
      logic [2:0] e_ex  [3] = '{3'b101, 3'b010, 3'b101};
      for (int i = 0; i < 3; i++) begin
         opcode = ops[i];
         mem_ready = 1'b1;
         step;
         #1;
         checks++; if ({alu_op, mem_rd} !== {e_alu[i], 1'b0}) begin errors++; $display("FAIL op%0d_decode got %b exp %b0", ops[i], {alu_op, mem_rd}, e_alu[i]); end
         step;
         #1;
         checks++; if ({mem_rd, mem_wr, acc_load} !== e_ex[i]) begin errors++; $display("FAIL op%0d_exec got %b exp %b", ops[i], {mem_rd, mem_wr, acc_load}, e_ex[i]); end
         checks++; if (alu_op !== e_alu[i]) begin errors++; $display("FAIL op%0d_exec_alu got %0d exp %0d", ops[i], alu_op, e_alu[i]); end
         step;
         mem_ready = 1'b0;
         #1;
         checks++; if ({mem_rd, mem_wr, acc_load, busy} !== 4'b1001) begin errors++; $display("FAIL op%0d_refetch got %b exp 1001", ops[i], {mem_rd, mem_wr, acc_load, busy}); end
      end
   endtask

   task automatic test_mult;
      opcode = 4'd4;
      mem_ready = 1'b1;
      step;
      #1;
      checks++; if (alu_op !== 3'd3) begin errors++; $display("FAIL mult_decode_alu got %0d exp 3", alu_op); end
      step;
      #1;
      checks++; if ({mem_rd, acc_load, alu_op} !== {2'b10, 3'd3}) begin errors++; $display("FAIL mult_exec got %b exp 10011", {mem_rd, acc_load, alu_op}); end
      for (int k = 1; k <= 3; k++) begin
         step;
         #1;
         checks++; if ({acc_load, mem_rd, busy, alu_op} !== {(k == 3), 2'b01, 3'd3}) begin errors++; $display("FAIL mult_wait%0d got %b exp %b", k, {acc_load, mem_rd, busy, alu_op}, {(k == 3), 2'b01, 3'd3}); end
      end
      step;
      mem_ready = 1'b0;
      #1;
      checks++; if ({mem_rd, acc_load} !== 2'b10) begin errors++; $display("FAIL mult_refetch got %b exp 10", {mem_rd, acc_load}); end
   endtask

   task automatic test_illegal;
      opcode = 4'b1011;
      mem_ready = 1'b1;
      step;
      mem_ready = 1'b0;
      #1;
      checks++; if ({illegal, alu_op, pc_load} !== 5'b00000) begin errors++; $display("FAIL illegal_decode got %b exp 00000", {illegal, alu_op, pc_load}); end
      step;
      checks++; if ({halted, illegal, busy, mem_rd} !== 4'b1100) begin errors++; $display("FAIL illegal_halt got %b exp 1100", {halted, illegal, busy, mem_rd}); end
      start = 1'b1;
      step;
      start = 1'b0;
      #1;
      checks++; if ({mem_rd, halted, illegal} !== 3'b101) begin errors++; $display("FAIL illegal_resume got %b exp 101", {mem_rd, halted, illegal}); end
      rst = 1'b1;
      #1;
      checks++; if ({illegal, busy, mem_rd} !== 3'b000) begin errors++; $display("FAIL illegal_cleared got %b exp 000", {illegal, busy, mem_rd}); end
      step;
      rst = 1'b0;
   endtask

   task automatic test_nop;
      int strobes;
      strobes = 0;
      start = 1'b1;
      step;
      start = 1'b0;
      opcode = 4'd0;
      mem_ready = 1'b1;
      step;
      mem_ready = 1'b0;
      step;
      checks++; if ({halted, illegal, busy} !== 3'b100) begin errors++; $display("FAIL nop_halt got %b exp 100", {halted, illegal, busy}); end
      for (int i = 0; i < 3; i++) begin
         mem_ready = i[0];
         #1;
         strobes += int'(mem_rd) + int'(mem_wr) + int'(ir_load) + int'(pc_inc) + int'(pc_load) + int'(acc_load) + int'(!halted);
         step;
      end
      checks++; if (strobes !== 0) begin errors++; $display("FAIL nop_quiet got %0d exp 0", strobes); end
      mem_ready = 1'b0;
      start = 1'b1;
      step;
      start = 1'b0;
      #1;
      checks++; if ({mem_rd, halted} !== 2'b10) begin errors++; $display("FAIL nop_resume got %b exp 10", {mem_rd, halted}); end
      rst = 1'b1;
      step;
      rst = 1'b0;
   endtask

   task automatic test_wide_and_mul1;
      b_start = 1'b1;
      step;
      b_start = 1'b0;
      b_opcode = 6'b010001;
      b_ready = 1'b1;
      step;
      b_ready = 1'b0;
      #1;
      checks++; if ({b_alu, b_illegal} !== 4'b0000) begin errors++; $display("FAIL wide_decode got %b exp 0000", {b_alu, b_illegal}); end
      step;
      checks++; if ({b_halted, b_illegal} !== 2'b11) begin errors++; $display("FAIL wide_illegal got %b exp 11", {b_halted, b_illegal}); end
      b_start = 1'b1;
      step;
      b_start = 1'b0;
      b_opcode = 6'd4;
      b_ready = 1'b1;
      step;
      step;
      #1;
      checks++; if ({b_rd, b_ld, b_alu} !== {2'b10, 3'd3}) begin errors++; $display("FAIL mul1_exec got %b exp 10011", {b_rd, b_ld, b_alu}); end
      step;
      #1;
      checks++; if ({b_ld, b_rd, b_alu} !== {2'b10, 3'd3}) begin errors++; $display("FAIL mul1_first_wait got %b exp 10011", {b_ld, b_rd, b_alu}); end
      step;
      b_ready = 1'b0;
      #1;
      checks++; if ({b_rd, b_ld, b_illegal} !== 3'b101) begin errors++; $display("FAIL mul1_refetch got %b exp 101", {b_rd, b_ld, b_illegal}); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mem_ready = 1'b0; opcode = '0; acc = '0;
      b_start = 1'b0; b_ready = 1'b0; b_opcode = '0; b_acc = '0;
      test_reset;
      test_reset_mid_fetch;
      test_add_stall;
      test_jumps;
      test_load_set_sub;
      test_mult;
      test_illegal;
      test_nop;
      test_wide_and_mul1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter DATA_W, default 32, accumulator width in bits.
REQ-002 Parameter OPC_W, default 4, opcode width (min 4); opcode bits above [3:0] nonzero = illegal.
REQ-003 Parameter MUL_CYCLES, default 3, multiply latency in cycles (min 1).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin/resume execution; level-sampled in IDLE and HALT.
REQ-007 opcode  in  OPC_W  instruction opcode from instruction register; valid in DECODE.
REQ-008 acc  in  DATA_W  signed accumulator value; sampled in DECODE.
REQ-009 mem_ready  in  1  memory handshake: current mem_rd/mem_wr access completes this cycle.
REQ-010 mem_rd  out  1  memory read request.
REQ-011 mem_wr  out  1  memory write request (accumulator to memory).
REQ-012 ir_load  out  1  load instruction register.
REQ-013 pc_inc  out  1  increment program counter.
REQ-014 pc_load  out  1  load program counter with jump target.
REQ-015 acc_load  out  1  load accumulator from ALU result.
REQ-016 alu_op  out  3  ALU operation: 0 pass-acc, 1 pass-mem, 2 add, 3 mult, 4 sub.
REQ-017 busy  out  1  high in every state except IDLE and HALT.
REQ-018 halted  out  1  high in HALT.
REQ-019 illegal  out  1  sticky flag: illegal opcode decoded.

Function
REQ-020 States SHALL be IDLE, FETCH, DECODE, EXEC, MUL_WAIT, HALT; outputs registered/derived from state only, no X on any output in any state.
REQ-021 IDLE: all outputs 0; start=1 -> FETCH next cycle.
REQ-022 FETCH: mem_rd=1 held until mem_ready; in the mem_ready cycle ir_load=1 and pc_inc=1 (one cycle each) -> DECODE; mem_ready=0 -> stay, no timeout.
REQ-023 DECODE: one cycle; opcode map: 0 NOP, 1 LOAD, 2 SET, 3 ADD, 4 MULT, 5 JNZ, 6 JZ, 7 JMP, 8 SUB; 9-15 illegal.
REQ-024 NOP -> HALT; illegal -> HALT with illegal set to 1 the following cycle.
REQ-025 JMP: pc_load=1 in DECODE; JNZ: pc_load=(acc!=0); JZ: pc_load=(acc==0); all three -> FETCH next cycle.
REQ-026 LOAD/ADD/SUB/MULT -> EXEC with mem_rd=1; SET -> EXEC with mem_wr=1; alu_op held constant for the whole instruction (LOAD 1, ADD 2, MULT 3, SUB 4, others 0).
REQ-027 EXEC: request held until mem_ready; on mem_ready: LOAD/ADD/SUB assert acc_load=1 that cycle -> FETCH; SET -> FETCH with no acc_load; MULT -> MUL_WAIT.
REQ-028 ADD SHALL NOT assert mem_wr; only SET writes memory.
REQ-029 MUL_WAIT: counter loaded with MUL_CYCLES-1 on entry, decrements each cycle; acc_load=1 in the cycle count==0 -> FETCH; MUL_CYCLES=1 gives acc_load on the first MUL_WAIT cycle.
REQ-030 mem_rd and mem_wr SHALL never both be 1; at most one of pc_inc/pc_load per cycle.
REQ-031 HALT: halted=1, other strobes 0; start=1 -> FETCH (resume at current PC); illegal remains set.
REQ-032 Instruction latency with zero-wait memory: jump 2 cycles, LOAD/ADD/SUB/SET 3, MULT 3+MUL_CYCLES.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, clear MUL_WAIT counter and illegal, drive all outputs 0, regardless of state or pending handshake.
REQ-034 After rst deasserts, no request issued until start=1 observed in IDLE.

Verification
REQ-035 Reset mid-FETCH with mem_rd=1, mem_ready=0: assert rst -> mem_rd=0, busy=0 same cycle; illegal=0.
REQ-036 start; ADD (3) with mem_ready stalled 2 cycles in EXEC -> mem_rd high 3 EXEC cycles, acc_load=1 once, alu_op=2 throughout, mem_wr never 1.
REQ-037 JNZ with acc=0 -> pc_load=0; JNZ with acc=-1 -> pc_load=1; JZ with acc=0 -> pc_load=1; each returns to FETCH next cycle.
REQ-038 MUL_CYCLES=3, MULT, zero-wait memory -> acc_load exactly 3 cycles after EXEC handshake cycle, alu_op=3, total 6 cycles.
REQ-039 Opcode 4'b1011 -> HALT, halted=1, illegal=1; start -> FETCH, illegal still 1; rst -> illegal=0.
REQ-040 NOP -> HALT with halted=1 and no strobes until start; OPC_W=6 with opcode 6'b010001 -> illegal=1.
